minimax_rf_param: RTL and testbench
===================================

# minimax_rf_param

Parametrised register file for the minimax core family: XLEN-bit data, NREG architectural registers (32 for RV32I, 16 for RV32E), two combinational read ports, one synchronous write port, and an optional write-to-read bypass. A built-in clear sequencer zeroes the storage after reset or on request, so the array itself needs no reset. It sits between decode and the ALU/writeback path, where the single-port fixed-size register file sits today.

## Interface
- XLEN, 32, data width in bits (≥8).
- NREG, 32, number of architectural registers (16 or 32); x0 is not stored.
- BYPASS, 1, 1 = a same-cycle write is visible on the read ports; 0 = reads return stored contents only.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- addrS  in  5  source read address.
- addrD  in  5  destination read address.
- waddr  in  5  write address.
- new_value  in  XLEN  write data.
- we  in  1  write enable.
- clear  in  1  single-cycle request to re-zero all registers.
- rS  out  XLEN  value of register addrS.
- rD  out  XLEN  value of register addrD.
- ready  out  1  high when the file is in RUN (accepting writes, reads valid).
- illegal  out  1  registered flag: the previous cycle accessed an address ≥ NREG.

## Operation
- FSM states: CLEAR and RUN.
- Reset forces CLEAR with idx = 1, ready = 0, and illegal = 0.
- CLEAR state:
  - Each rising edge writes 0 to entry idx, then idx increments.
  - After the edge that clears entry NREG-1, the state becomes RUN.
  - rS and rD read as 0 regardless of address.
  - we is ignored.
- RUN state:
  - On a rising edge, if we, waddr ≠ 0 and waddr < NREG, entry waddr takes new_value. All other writes are dropped.
  - Asserting clear returns the FSM to CLEAR with idx = 1 at the next edge.
  - clear in CLEAR is ignored; the sequence does not restart.
- Read rules:
  - Address 0 reads 0.
  - An address ≥ NREG reads 0.
  - Otherwise the port reads the stored entry.
  - If BYPASS=1, we is high, the state is RUN, and the write address equals the read address and is a legal, nonzero address, the port returns new_value combinationally.
- illegal is registered each edge in RUN: the OR over addrS, addrD and (waddr when we) of address ≥ NREG. It is held at 0 in CLEAR. It is always 0 when NREG = 32.
- Simultaneous clear and we in RUN: clear wins and the write is dropped.
- reset asserted mid-CLEAR or mid-RUN: immediate return to CLEAR with idx = 1. Contents are zeroed again by the new sequence.
- Width rules:
  - idx is 5 bits.
  - Address comparisons are unsigned 5-bit.
  - Storage is XLEN × (NREG-1) entries.

## Timing
- Read latency: 0 cycles (combinational from addresses, storage and, with BYPASS, new_value).
- Write latency: 1 edge. Without bypass, a read sees the new value on the cycle after the write edge.
- Clear duration: NREG-1 rising edges after reset deasserts, or after the edge that samples clear. ready rises after the last of these edges.
  - NREG = 32: ready is high from the 31st edge onward.
  - NREG = 16: ready is high from the 15th edge onward.
- ready falls on the edge that samples clear.
- Reset values: ready = 0, illegal = 0. rS and rD are 0 because the FSM is in CLEAR.

## Structure
- Package minimax_rf_pkg holds:
  - the state enum (CLEAR, RUN);
  - the constants NREG_RV32I = 32 and NREG_RV32E = 16;
  - the default XLEN.
- Sub-module minimax_rf_clear_seq contains the FSM, idx counter, ready output, and the clear write-enable/address mux into the storage array.
- The top level holds the storage array, read muxes, bypass logic and illegal register.
- Storage has no reset, so it remains synthesisable to flops or latch RAM.

## Test plan
- Reset release, NREG=32 → ready is 0 for 30 edges and 1 after the 31st; rS = rD = 0 throughout CLEAR, including while we = 1 with waddr = 5.
- In RUN: write x7 = 0xDEADBEEF, then read addrS = 7 and addrD = 0 next cycle → rS = 0xDEADBEEF, rD = 0. A write to x0 leaves reads of address 0 at 0.
- BYPASS=1: we = 1, waddr = 3, new_value = 0x12345678, addrS = 3 in the same cycle → rS = 0x12345678 before the edge. With BYPASS=0, rS shows the old value until after the edge.
- NREG=16: read addrS = 20 → rS = 0 and illegal = 1 on the next cycle. A write to waddr = 17 is dropped, with no alias to x1.
- Fill x1..x31 with nonzero values, pulse clear together with we to x9 → the x9 write is dropped, ready falls, and after 31 edges all registers read 0 with ready = 1.
- Assert reset at idx = 10 mid-CLEAR → the sequence restarts at idx = 1 and ready rises only after 31 edges from reset release.

Source files
------------

// File: rtl/minimax_rf_pkg.sv
// rtl/minimax_rf_pkg.sv - shared types and constants for the minimax register file
package minimax_rf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int NREG_RV32I   = 32;
  localparam int NREG_RV32E   = 16;
  localparam int XLEN_DEFAULT = 32;

endpackage

// File: rtl/minimax_rf_clear_seq.sv
// rtl/minimax_rf_clear_seq.sv - clear sequencer FSM and storage write-port mux
module minimax_rf_clear_seq
  import minimax_rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_RV32I
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] new_value,
  output logic            run,
  output logic            ready,
  output logic            wr_en,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] wr_data
);

  localparam logic [5:0] NREG_W = 6'(NREG);
  localparam logic [4:0] LAST   = 5'(NREG - 1);

  rf_state_e  state;
  logic [4:0] idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      idx   <= 5'd1;
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          idx <= idx + 5'd1;
          if (idx == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (clear) begin
            state <= CLEAR;
            idx   <= 5'd1;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
          idx   <= 5'd1;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign run = (state == RUN);

  // clear takes priority over a coincident write; x0 and out-of-range writes are dropped
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = waddr;
    wr_data = new_value;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = idx;
      wr_data = '0;
    end else if (we && !clear && waddr != 5'd0 && {1'b0, waddr} < NREG_W) begin
      wr_en = 1'b1;
    end
  end

endmodule

// File: rtl/minimax_rf_param.sv
// rtl/minimax_rf_param.sv - parametrised 2R1W register file with optional write bypass
module minimax_rf_param
  import minimax_rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREG   = NREG_RV32I,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      addrS,
  input  logic [4:0]      addrD,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] new_value,
  input  logic            we,
  input  logic            clear,
  output logic [XLEN-1:0] rS,
  output logic [XLEN-1:0] rD,
  output logic            ready,
  output logic            illegal
);

  localparam int         AW     = $clog2(NREG);
  localparam logic [5:0] NREG_W = 6'(NREG);

  logic            run;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] regs [1:NREG-1];

  function automatic logic legal(input logic [4:0] a);
    return {1'b0, a} < NREG_W;
  endfunction

  minimax_rf_clear_seq #(
    .XLEN(XLEN),
    .NREG(NREG)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .we       (we),
    .waddr    (waddr),
    .new_value(new_value),
    .run      (run),
    .ready    (ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  // no reset on the array: the clear sequencer zeroes it instead
  always_ff @(posedge clk) begin
    if (wr_en) regs[wr_addr[AW-1:0]] <= wr_data;
  end

  always_comb begin
    rS = '0;
    if (run && addrS != 5'd0 && legal(addrS)) begin
      if (BYPASS != 0 && we && waddr == addrS) rS = new_value;
      else rS = regs[addrS[AW-1:0]];
    end
  end

  always_comb begin
    rD = '0;
    if (run && addrD != 5'd0 && legal(addrD)) begin
      if (BYPASS != 0 && we && waddr == addrD) rD = new_value;
      else rD = regs[addrD[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal <= 1'b0;
    else if (!run) illegal <= 1'b0;
    else illegal <= !legal(addrS) || !legal(addrD) || (we && !legal(waddr));
  end

endmodule

// File: tb/tb_minimax_rf_param.sv
// tb/tb_minimax_rf_param.sv - directed table-driven bench for minimax_rf_param
module tb_minimax_rf_param;
  import minimax_rf_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  addrS, addrD, waddr;
  logic [31:0] new_value;
  logic        we, clear;

  logic [31:0] rS_b, rD_b, rS_n, rD_n, rS_16, rD_16;
  logic        ready_b, ready_n, ready_16, ill_b, ill_n, ill_16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  minimax_rf_param #(.XLEN(32), .NREG(NREG_RV32I), .BYPASS(1)) u_b (
    .clk(clk), .reset(reset), .addrS(addrS), .addrD(addrD), .waddr(waddr),
    .new_value(new_value), .we(we), .clear(clear), .rS(rS_b), .rD(rD_b),
    .ready(ready_b), .illegal(ill_b));

  minimax_rf_param #(.XLEN(32), .NREG(NREG_RV32I), .BYPASS(0)) u_n (
    .clk(clk), .reset(reset), .addrS(addrS), .addrD(addrD), .waddr(waddr),
    .new_value(new_value), .we(we), .clear(clear), .rS(rS_n), .rD(rD_n),
    .ready(ready_n), .illegal(ill_n));

  minimax_rf_param #(.XLEN(32), .NREG(NREG_RV32E), .BYPASS(1)) u_16 (
    .clk(clk), .reset(reset), .addrS(addrS), .addrD(addrD), .waddr(waddr),
    .new_value(new_value), .we(we), .clear(clear), .rS(rS_16), .rD(rD_16),
    .ready(ready_16), .illegal(ill_16));

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] nv;
    logic [4:0]  as;
    logic [4:0]  ad;
    logic [31:0] s_b;
    logic [31:0] d_b;
    logic [31:0] s_n;
    logic [31:0] s_16;
    logic        ill16;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; addrS = '0; addrD = '0; waddr = '0; new_value = '0; we = 1'b0; clear = 1'b0;
    repeat (3) tick();
    chk("reset_ready", {31'd0, ready_b}, 32'd0);
    chk("reset_illegal", {31'd0, ill_16}, 32'd0);
    chk("reset_rS", rS_b, 32'd0);
    reset = 1'b0;

    // CLEAR after reset release, with a write attempt that must be ignored
    we = 1'b1; waddr = 5'd5; new_value = 32'hAAAA_AAAA; addrS = 5'd5; addrD = 5'd5;
    for (int e = 1; e <= 31; e++) begin
      #1;
      if (e <= 31 && !ready_b) begin
        chk("clr_rS", rS_b, 32'd0);
        chk("clr_rD", rD_b, 32'd0);
      end
      tick();
      chk($sformatf("ready32_e%0d", e), {31'd0, ready_b}, {31'd0, e >= 31});
      chk($sformatf("ready16_e%0d", e), {31'd0, ready_16}, {31'd0, e >= 15});
      if (e == 29) we = 1'b0;
    end

    vecs[0]  = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd0,  32'h0,         32'h0,         32'h0,         32'hAAAA_AAAA, 1'b0};
    vecs[1]  = '{1'b1, 5'd7,  32'hDEADBEEF,  5'd7,  5'd0,  32'hDEADBEEF,  32'h0,         32'h0,         32'hDEADBEEF,  1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd0,  32'hDEADBEEF,  32'h0,         32'hDEADBEEF,  32'hDEADBEEF,  1'b0};
    vecs[3]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0,         1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd7,  32'h0,         32'hDEADBEEF,  32'h0,         32'h0,         1'b0};
    vecs[5]  = '{1'b1, 5'd3,  32'h12345678,  5'd3,  5'd7,  32'h12345678,  32'hDEADBEEF,  32'h0,         32'h12345678,  1'b0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,         5'd3,  5'd3,  32'h12345678,  32'h12345678,  32'h12345678,  32'h12345678,  1'b0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,         5'd20, 5'd0,  32'h0,         32'h0,         32'h0,         32'h0,         1'b1};
    vecs[8]  = '{1'b1, 5'd17, 32'hCAFEF00D,  5'd1,  5'd17, 32'h0,         32'hCAFEF00D,  32'h0,         32'h0,         1'b1};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,         5'd1,  5'd17, 32'h0,         32'hCAFEF00D,  32'h0,         32'h0,         1'b1};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         5'd1,  5'd2,  32'h0,         32'h0,         32'h0,         32'h0,         1'b0};
    vecs[11] = '{1'b1, 5'd31, 32'h0F0F0F0F,  5'd31, 5'd31, 32'h0F0F0F0F,  32'h0F0F0F0F,  32'h0,         32'h0,         1'b1};
    vecs[12] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd5,  32'h0F0F0F0F,  32'h0,         32'h0F0F0F0F,  32'h0,         1'b1};

    for (int i = 0; i < 13; i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; new_value = vecs[i].nv;
      addrS = vecs[i].as; addrD = vecs[i].ad;
      #1;
      chk($sformatf("v%0d_rS_byp", i), rS_b, vecs[i].s_b);
      chk($sformatf("v%0d_rD_byp", i), rD_b, vecs[i].d_b);
      chk($sformatf("v%0d_rS_nobyp", i), rS_n, vecs[i].s_n);
      chk($sformatf("v%0d_rS_16", i), rS_16, vecs[i].s_16);
      tick();
      chk($sformatf("v%0d_ill16", i), {31'd0, ill_16}, {31'd0, vecs[i].ill16});
      chk($sformatf("v%0d_ill32", i), {31'd0, ill_b}, 32'd0);
    end

    // fill x1..x31, then clear with a coincident write to x9
    we = 1'b1;
    for (int r = 1; r < 32; r++) begin
      waddr = 5'(r); new_value = 32'h0101_0100 + 32'(r);
      tick();
    end
    we = 1'b0;
    for (int r = 1; r < 32; r++) begin
      addrS = 5'(r);
      #1;
      chk($sformatf("fill_x%0d", r), rS_n, 32'h0101_0100 + 32'(r));
    end
    clear = 1'b1; we = 1'b1; waddr = 5'd9; new_value = 32'h9999_9999;
    tick();
    clear = 1'b0; we = 1'b0;
    chk("clear_ready_fall", {31'd0, ready_n}, 32'd0);
    for (int e = 1; e <= 31; e++) begin
      tick();
      chk($sformatf("clr_ready_e%0d", e), {31'd0, ready_n}, {31'd0, e >= 31});
    end
    for (int r = 1; r < 32; r++) begin
      addrS = 5'(r); addrD = 5'(r);
      #1;
      chk($sformatf("zero_x%0d", r), rS_n, 32'd0);
    end

    // reset mid-CLEAR at idx = 10
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    #1;
    chk("midclr_reset_ready", {31'd0, ready_b}, 32'd0);
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      tick();
      chk($sformatf("rst_ready_e%0d", e), {31'd0, ready_b}, {31'd0, e >= 31});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
